// File: rtl/alu_result_display.sv
// rtl/alu_result_display.sv - ALU result to 4-digit multiplexed seven-segment display
//
// Converts the 8-bit ALU result to decimal with an iterative double-dabble
// engine. The result is shown as signed (two's complement) or unsigned, and the
// four digits are scanned with a refresh counter.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   result      [7:0] ALU result to display
//   signed_mode 1 = show result as -128..127, 0 = show as 0..255
//   seg         [6:0] segments {g,f,e,d,c,b,a}, active-low, registered
//   an          [3:0] digit enables, active-low one-hot; an[0] = ones digit
//   busy        high while a conversion is in progress
//   conv_done   one-cycle pulse when the display registers take a new value
module alu_result_display #(
  parameter int REFRESH_DIV   = 50000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] result,
  input  logic       signed_mode,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy,
  output logic       conv_done
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(REFRESH_DIV - 1);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'h3F;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t      state;
  logic [7:0]  sh;
  logic [11:0] bcd;
  logic [11:0] bcd_adj;
  logic [2:0]  iter;
  logic        neg;

  // Display registers hold already-encoded segment patterns
  logic [6:0]  disp3, disp2, disp1, disp0;

  logic [CW-1:0] refresh_cnt;
  logic [1:0]    idx;
  logic [1:0]    next_idx;
  logic [6:0]    seg_next;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = SEG_BLANK;
    endcase
  endfunction

  // Double-dabble correction applied before every shift
  always_comb begin
    bcd_adj = bcd;
    if (bcd[3:0]  >= 4'd5) bcd_adj[3:0]  = bcd[3:0]  + 4'd3;
    if (bcd[7:4]  >= 4'd5) bcd_adj[7:4]  = bcd[7:4]  + 4'd3;
    if (bcd[11:8] >= 4'd5) bcd_adj[11:8] = bcd[11:8] + 4'd3;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sh        <= 8'd0;
      bcd       <= 12'd0;
      iter      <= 3'd0;
      neg       <= 1'b0;
      busy      <= 1'b0;
      conv_done <= 1'b0;
      disp3     <= SEG_BLANK;
      disp2     <= SEG_BLANK;
      disp1     <= SEG_BLANK;
      disp0     <= 7'h40;
    end else begin
      conv_done <= 1'b0;
      case (state)
        IDLE: begin
          neg <= signed_mode & result[7];
          // 8-bit negation of 0x80 yields 0x80, which is the required magnitude 128
          sh    <= (signed_mode & result[7]) ? (8'd0 - result) : result;
          bcd   <= 12'd0;
          iter  <= 3'd0;
          busy  <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: begin
          bcd  <= {bcd_adj[10:0], sh[7]};
          sh   <= {sh[6:0], 1'b0};
          iter <= iter + 3'd1;
          if (iter == 3'd7) state <= COMMIT;
        end
        COMMIT: begin
          disp3     <= neg ? SEG_MINUS : SEG_BLANK;
          disp2     <= (BLANK_LEADING && bcd[11:8] == 4'd0) ? SEG_BLANK : enc(bcd[11:8]);
          disp1     <= (BLANK_LEADING && bcd[11:8] == 4'd0 && bcd[7:4] == 4'd0)
                       ? SEG_BLANK : enc(bcd[7:4]);
          disp0     <= enc(bcd[3:0]);
          busy      <= 1'b0;
          conv_done <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign next_idx = idx + 2'd1;

  always_comb begin
    seg_next = SEG_BLANK;
    case (next_idx)
      2'd0: seg_next = disp0;
      2'd1: seg_next = disp1;
      2'd2: seg_next = disp2;
      2'd3: seg_next = disp3;
      default: seg_next = SEG_BLANK;
    endcase
  end

  // seg and an only move on a tick, so a commit never changes a lit digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refresh_cnt <= '0;
      idx         <= 2'd0;
      an          <= 4'hF;
      seg         <= SEG_BLANK;
    end else if (refresh_cnt == LAST) begin
      refresh_cnt <= '0;
      idx         <= next_idx;
      an          <= ~(4'b0001 << next_idx);
      seg         <= seg_next;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

endmodule
